// File: rtl/ram_request_arbiter.sv
// Two-port SDRAM request arbiter: IDLE -> BUSY -> DONE handshake toward a single RAM port.
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default build gives port A fixed priority.
module ram_request_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_stb,
    input  logic        a_we,
    input  logic [23:0] a_addr,
    input  logic [31:0] a_data_in,
    output logic [31:0] a_data_out,
    output logic        a_ack,
    input  logic        b_stb,
    input  logic        b_we,
    input  logic [23:0] b_addr,
    input  logic [31:0] b_data_in,
    output logic [31:0] b_data_out,
    output logic        b_ack,
    output logic        ram_stb,
    output logic        ram_we,
    output logic [23:0] ram_addr,
    output logic [31:0] ram_data_out,
    input  logic [31:0] ram_data_in,
    input  logic        ram_ack,
    output logic        grant_b
);

    localparam int unsigned AW = 24;
    localparam int unsigned DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          r_state, w_state_nxt;
    logic            r_ram_stb, w_ram_stb_nxt;
    logic            r_ram_we, w_ram_we_nxt;
    logic [AW-1:0]   r_ram_addr, w_ram_addr_nxt;
    logic [DW-1:0]   r_ram_data, w_ram_data_nxt;
    logic [DW-1:0]   r_a_data, w_a_data_nxt;
    logic [DW-1:0]   r_b_data, w_b_data_nxt;
    logic            r_a_ack, w_a_ack_nxt;
    logic            r_b_ack, w_b_ack_nxt;
    logic            r_grant_b, w_grant_b_nxt;
    logic            w_req;
    logic            w_win_b;

    assign w_req = a_stb | b_stb;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    // 1 when port B held the most recent grant; reset favours A next.
    logic r_last_b;

    assign w_win_b = b_stb & (~a_stb | ~r_last_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_b <= 1'b1;
        end else if (r_state == ST_IDLE && w_req) begin
            r_last_b <= w_win_b;
        end
    end
`else
    assign w_win_b = b_stb & ~a_stb;
`endif

    // Next-state and next-output logic; everything holds unless the state says otherwise.
    always_comb begin
        w_state_nxt    = r_state;
        w_ram_stb_nxt  = r_ram_stb;
        w_ram_we_nxt   = r_ram_we;
        w_ram_addr_nxt = r_ram_addr;
        w_ram_data_nxt = r_ram_data;
        w_a_data_nxt   = r_a_data;
        w_b_data_nxt   = r_b_data;
        w_a_ack_nxt    = 1'b0;
        w_b_ack_nxt    = 1'b0;
        w_grant_b_nxt  = r_grant_b;

        case (r_state)
            ST_IDLE: begin
                w_grant_b_nxt = 1'b0;
                if (w_req) begin
                    w_state_nxt    = ST_BUSY;
                    w_ram_stb_nxt  = 1'b1;
                    w_grant_b_nxt  = w_win_b;
                    w_ram_we_nxt   = w_win_b ? b_we      : a_we;
                    w_ram_addr_nxt = w_win_b ? b_addr    : a_addr;
                    w_ram_data_nxt = w_win_b ? b_data_in : a_data_in;
                end
            end
            ST_BUSY: begin
                if (ram_ack) begin
                    w_state_nxt   = ST_DONE;
                    w_ram_stb_nxt = 1'b0;
                    if (r_grant_b) begin
                        w_b_data_nxt = ram_data_in;
                        w_b_ack_nxt  = 1'b1;
                    end else begin
                        w_a_data_nxt = ram_data_in;
                        w_a_ack_nxt  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                // One dead cycle lets the requester drop stb before arbitration reopens.
                w_state_nxt   = ST_IDLE;
                w_grant_b_nxt = 1'b0;
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_ram_stb_nxt = 1'b0;
                w_grant_b_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_ram_stb  <= 1'b0;
            r_ram_we   <= 1'b0;
            r_ram_addr <= '0;
            r_ram_data <= '0;
            r_a_data   <= '0;
            r_b_data   <= '0;
            r_a_ack    <= 1'b0;
            r_b_ack    <= 1'b0;
            r_grant_b  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ram_stb  <= w_ram_stb_nxt;
            r_ram_we   <= w_ram_we_nxt;
            r_ram_addr <= w_ram_addr_nxt;
            r_ram_data <= w_ram_data_nxt;
            r_a_data   <= w_a_data_nxt;
            r_b_data   <= w_b_data_nxt;
            r_a_ack    <= w_a_ack_nxt;
            r_b_ack    <= w_b_ack_nxt;
            r_grant_b  <= w_grant_b_nxt;
        end
    end

    assign ram_stb      = r_ram_stb;
    assign ram_we       = r_ram_we;
    assign ram_addr     = r_ram_addr;
    assign ram_data_out = r_ram_data;
    assign a_data_out   = r_a_data;
    assign b_data_out   = r_b_data;
    assign a_ack        = r_a_ack;
    assign b_ack        = r_b_ack;
    assign grant_b      = r_grant_b;

endmodule

// File: tb/tb_ram_request_arbiter.sv
// Scoreboard bench for ram_request_arbiter: stimulus queues expected RAM requests and acks, a monitor checks them.
module tb_ram_request_arbiter;

    logic        clk;
    logic        rst_n;
    logic        a_stb, a_we, b_stb, b_we;
    logic [23:0] a_addr, b_addr;
    logic [31:0] a_data_in, b_data_in;
    logic [31:0] a_data_out, b_data_out;
    logic        a_ack, b_ack;
    logic        ram_stb, ram_we;
    logic [23:0] ram_addr;
    logic [31:0] ram_data_out;
    logic [31:0] ram_data_in;
    logic        ram_ack;
    logic        grant_b;

    logic        resp_ack;
    logic [31:0] resp_data;
    logic        spur_ack;
    logic [31:0] spur_data;
    int          ram_delay;

    assign ram_ack     = resp_ack | spur_ack;
    assign ram_data_in = spur_ack ? spur_data : resp_data;

    ram_request_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .a_stb(a_stb), .a_we(a_we), .a_addr(a_addr), .a_data_in(a_data_in),
        .a_data_out(a_data_out), .a_ack(a_ack),
        .b_stb(b_stb), .b_we(b_we), .b_addr(b_addr), .b_data_in(b_data_in),
        .b_data_out(b_data_out), .b_ack(b_ack),
        .ram_stb(ram_stb), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_data_out(ram_data_out), .ram_data_in(ram_data_in), .ram_ack(ram_ack),
        .grant_b(grant_b)
    );

    typedef struct {
        logic        we;
        logic [23:0] addr;
        logic [31:0] data;
        logic        gb;
    } req_t;

    typedef struct {
        logic        port_b;
        logic [31:0] data;
        int          cyc;
    } rsp_t;

    req_t        req_q[$];
    rsp_t        rsp_q[$];
    logic [31:0] rd_q[$];

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          ack_cnt = 0;
    logic [31:0] model_a = 32'd0;
    logic [31:0] model_b = 32'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // RAM model: acks ram_delay cycles into BUSY with the next queued read word.
    initial begin
        int cnt;
        logic given;
        cnt = 0;
        given = 1'b0;
        resp_ack = 1'b0;
        resp_data = 32'd0;
        forever begin
            @(negedge clk);
            if (ram_stb && !given) begin
                if (cnt == ram_delay) begin
                    resp_ack  = 1'b1;
                    resp_data = (rd_q.size() != 0) ? rd_q.pop_front() : 32'd0;
                    given     = 1'b1;
                end else begin
                    cnt++;
                end
            end else begin
                resp_ack = 1'b0;
                if (!ram_stb) begin
                    given = 1'b0;
                    cnt   = 0;
                end
            end
        end
    end

    // Monitor: checks each new RAM request and each requester ack against the queues.
    initial begin
        logic prev_stb;
        req_t rq;
        rsp_t rs;
        prev_stb = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (ram_stb && !prev_stb) begin
                if (req_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_ram_req: got ram_stb=1 addr=%h, expected no request", ram_addr);
                end else begin
                    rq = req_q.pop_front();
                    check("ram_we",       32'(ram_we),   32'(rq.we));
                    check("ram_addr",     32'(ram_addr), 32'(rq.addr));
                    check("ram_data_out", ram_data_out,  rq.data);
                    check("grant_b",      32'(grant_b),  32'(rq.gb));
                end
            end
            prev_stb = ram_stb;
            if (a_ack || b_ack) begin
                check("ack_exclusive", 32'(a_ack & b_ack), 32'd0);
                check("ram_stb_in_done", 32'(ram_stb), 32'd0);
                if (rsp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_ack: got a_ack=%0b b_ack=%0b, expected none", a_ack, b_ack);
                end else begin
                    rs = rsp_q.pop_front();
                    check("ack_port_b", 32'(b_ack), 32'(rs.port_b));
                    check("ack_cycle", 32'(cyc), 32'(rs.cyc));
                    check("grant_b_done", 32'(grant_b), 32'(rs.port_b));
                    if (rs.port_b) begin
                        check("b_data_out", b_data_out, rs.data);
                        check("loser_a_data", a_data_out, model_a);
                        model_b = rs.data;
                    end else begin
                        check("a_data_out", a_data_out, rs.data);
                        check("loser_b_data", b_data_out, model_b);
                        model_a = rs.data;
                    end
                    ack_cnt++;
                end
            end
        end
    end

    task automatic push_req(input logic we, input logic [23:0] addr, input logic [31:0] data, input logic gb);
        req_t r;
        r.we = we; r.addr = addr; r.data = data; r.gb = gb;
        req_q.push_back(r);
    endtask

    task automatic push_rsp(input logic pb, input logic [31:0] data, input int c);
        rsp_t r;
        r.port_b = pb; r.data = data; r.cyc = c;
        rsp_q.push_back(r);
        rd_q.push_back(data);
    endtask

    task automatic wait_rsp(input string name);
        int n;
        n = 0;
        while (rsp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (rsp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: got %0d pending acks, expected 0", name, rsp_q.size());
            rsp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst_n = 1'b0;
        a_stb = 1'b0; a_we = 1'b0; a_addr = 24'd0; a_data_in = 32'd0;
        b_stb = 1'b0; b_we = 1'b0; b_addr = 24'd0; b_data_in = 32'd0;
        spur_ack = 1'b0; spur_data = 32'd0; ram_delay = 0;

        #3;
        check("rst_ram_stb", 32'(ram_stb), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_data", ram_data_out, 32'd0);
        check("rst_acks", 32'({a_ack, b_ack, grant_b}), 32'd0);
        check("rst_data_out", a_data_out | b_data_out, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single read on A, RAM acks in 2nd BUSY cycle.
        c = cyc;
        a_stb = 1'b1; a_we = 1'b0; a_addr = 24'h000100; a_data_in = 32'h0;
        ram_delay = 1;
        push_req(1'b0, 24'h000100, 32'h0, 1'b0);
        push_rsp(1'b0, 32'hDEADBEEF, c + 3);
        wait_rsp("read_a");
        a_stb = 1'b0;
        repeat (3) @(negedge clk);

        // Single write on B, RAM acks in 1st BUSY cycle.
        c = cyc;
        b_stb = 1'b1; b_we = 1'b1; b_addr = 24'h00FFFF; b_data_in = 32'h12345678;
        ram_delay = 0;
        push_req(1'b1, 24'h00FFFF, 32'h12345678, 1'b1);
        push_rsp(1'b1, 32'h0BADF00D, c + 2);
        wait_rsp("write_b");
        b_stb = 1'b0;
        repeat (3) @(negedge clk);

        // Both ports held for four transfers.
        c = cyc;
        a_stb = 1'b1; a_we = 1'b0; a_addr = 24'h000200; a_data_in = 32'h11111111;
        b_stb = 1'b1; b_we = 1'b1; b_addr = 24'h000300; b_data_in = 32'h22222222;
        ram_delay = 0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        push_req(1'b0, 24'h000200, 32'h11111111, 1'b0); push_rsp(1'b0, 32'hA0000000, c + 2);
        push_req(1'b1, 24'h000300, 32'h22222222, 1'b1); push_rsp(1'b1, 32'hA1000001, c + 5);
        push_req(1'b0, 24'h000200, 32'h11111111, 1'b0); push_rsp(1'b0, 32'hA2000002, c + 8);
        push_req(1'b1, 24'h000300, 32'h22222222, 1'b1); push_rsp(1'b1, 32'hA3000003, c + 11);
`else
        push_req(1'b0, 24'h000200, 32'h11111111, 1'b0); push_rsp(1'b0, 32'hA0000000, c + 2);
        push_req(1'b0, 24'h000200, 32'h11111111, 1'b0); push_rsp(1'b0, 32'hA1000001, c + 5);
        push_req(1'b0, 24'h000200, 32'h11111111, 1'b0); push_rsp(1'b0, 32'hA2000002, c + 8);
        push_req(1'b0, 24'h000200, 32'h11111111, 1'b0); push_rsp(1'b0, 32'hA3000003, c + 11);
`endif
        wait_rsp("simultaneous");
        a_stb = 1'b0; b_stb = 1'b0;
        repeat (3) @(negedge clk);

        // Address and stb change mid-BUSY must not disturb the latched request.
        c = cyc;
        a_stb = 1'b1; a_we = 1'b0; a_addr = 24'h000010; a_data_in = 32'h0;
        ram_delay = 3;
        push_req(1'b0, 24'h000010, 32'h0, 1'b0);
        push_rsp(1'b0, 32'h10101010, c + 5);
        @(negedge clk);
        a_addr = 24'h000020; a_stb = 1'b0;
        repeat (2) begin
            @(negedge clk);
            #1;
            check("hold_ram_addr", 32'(ram_addr), 32'h000010);
            check("hold_ram_stb", 32'(ram_stb), 32'd1);
        end
        wait_rsp("addr_hold");
        repeat (3) @(negedge clk);

        // Reset in the 2nd BUSY cycle abandons the transfer.
        a_stb = 1'b1; a_we = 1'b0; a_addr = 24'h000040; a_data_in = 32'h0;
        ram_delay = 5;
        push_req(1'b0, 24'h000040, 32'h0, 1'b0);
        @(negedge clk);
        a_stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("busy_rst_ram_stb", 32'(ram_stb), 32'd0);
        check("busy_rst_acks", 32'({a_ack, b_ack, grant_b}), 32'd0);
        check("busy_rst_a_data", a_data_out, 32'd0);
        model_a = 32'd0;
        model_b = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        rd_q.delete();

        c = cyc;
        a_stb = 1'b1; a_we = 1'b0; a_addr = 24'h000030; a_data_in = 32'h0;
        ram_delay = 0;
        push_req(1'b0, 24'h000030, 32'h0, 1'b0);
        push_rsp(1'b0, 32'h55AA55AA, c + 2);
        wait_rsp("after_reset");
        a_stb = 1'b0;
        repeat (3) @(negedge clk);

        // Spurious ram_ack in IDLE with no requests.
        spur_data = 32'hBAD0BAD0;
        spur_ack = 1'b1;
        repeat (2) @(negedge clk);
        spur_ack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("spur_a_data", a_data_out, model_a);
        check("spur_b_data", b_data_out, model_b);
        check("spur_ram_stb", 32'(ram_stb), 32'd0);
        check("spur_a_data_abs", a_data_out, 32'h55AA55AA);

        check("req_q_empty", 32'(req_q.size()), 32'd0);
        check("total_acks", 32'(ack_cnt), 32'd8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ram_request_arbiter.md
RAM_REQUEST_ARBITER -- requirements
Module: ram_request_arbiter

Interface
REQ-001 The block SHALL provide these ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- a_stb  in  1  port A request (display refill, read-mostly).
- a_we  in  1  port A write enable.
- a_addr  in  24  port A word address [25:2].
- a_data_in  in  32  port A write data.
- a_data_out  out  32  port A read data.
- a_ack  out  1  port A completion pulse.
- b_stb, b_we, b_addr, b_data_in, b_data_out, b_ack  (same directions and widths as port A)  port B (drawing/CPU).
- ram_stb  out  1  request to the SDRAM interface.
- ram_we  out  1  write enable to the SDRAM interface.
- ram_addr  out  24  word address [25:2] to the SDRAM interface.
- ram_data_out  out  32  write data to the SDRAM interface.
- ram_data_in  in  32  read data from the SDRAM interface.
- ram_ack  in  1  completion from the SDRAM interface.
- grant_b  out  1  1 while port B owns the RAM (debug).

Function
REQ-002 The block SHALL have three states: IDLE, BUSY, DONE.
REQ-003 In IDLE with at least one stb high, the next edge SHALL select a winner, enter BUSY, and latch the winner's we/addr/data_in into ram_we/ram_addr/ram_data_out. ram_stb=1 from the first BUSY cycle.
REQ-004 In BUSY, ram_stb, ram_we, ram_addr and ram_data_out SHALL hold constant until ram_ack=1 is sampled; requester stb changes are ignored.
REQ-005 On the edge sampling ram_ack=1 in BUSY, the block SHALL:
- drop ram_stb;
- latch ram_data_in into the winner's data_out (for writes too);
- assert the winner's ack for exactly one cycle;
- enter DONE.
REQ-006 DONE SHALL last exactly one cycle and then return to IDLE, so a requester that drops stb after seeing ack is not re-granted.
REQ-007 Minimum latency, stb high in IDLE to requester ack, SHALL be 3 cycles when ram_ack arrives in the first BUSY cycle.
REQ-008 A loser's ack SHALL stay 0, and its data_out SHALL keep its previous value.
REQ-009 a_ack and b_ack SHALL never be 1 in the same cycle.
REQ-010 grant_b SHALL be 1 in BUSY/DONE when port B won, and 0 otherwise.
REQ-011 A ram_ack outside BUSY SHALL be ignored.
REQ-012 ram_stb SHALL never be asserted in IDLE or DONE.

Reset
REQ-013 While rst_n=0, the block SHALL force, asynchronously:
- state IDLE;
- ram_stb, ram_we, a_ack, b_ack, grant_b = 0;
- ram_addr, ram_data_out, a_data_out, b_data_out = 0;
- last_grant = B.
REQ-014 Reset asserted in BUSY SHALL drop ram_stb immediately and abandon the transfer with no ack to either port.

Configuration
REQ-015 With RAM_ARB_ROUND_ROBIN_EN defined, arbitration SHALL be round-robin:
- on simultaneous requests, the port not granted last wins;
- last_grant updates on entry to BUSY.
REQ-016 Without RAM_ARB_ROUND_ROBIN_EN, port A SHALL always win simultaneous requests, and last_grant SHALL be absent.
REQ-017 Both builds SHALL give a lone requester the grant regardless of history.

Verification
REQ-018 Single read: a_stb=1, a_we=0, a_addr=24'h000100; ram_ack on 2nd BUSY cycle with ram_data_in=32'hDEADBEEF -> ram_addr=24'h000100, ram_we=0, a_data_out=32'hDEADBEEF with a_ack pulse 4 cycles after a_stb.
REQ-019 Single write: b_stb=1, b_we=1, b_addr=24'h00FFFF, b_data_in=32'h12345678; ram_ack in 1st BUSY cycle -> ram_data_out=32'h12345678, ram_we=1, grant_b=1, b_ack pulse 3 cycles after b_stb.
REQ-020 Simultaneous a_stb and b_stb held for 4 transfers -> round-robin order A,B,A,B; fixed-priority order A,A,A,A with B starved.
REQ-021 Port A changes a_addr from 24'h000010 to 24'h000020 mid-BUSY -> ram_addr stays 24'h000010 until ram_ack.
REQ-022 rst_n low in the 2nd BUSY cycle -> ram_stb=0 within the same cycle, no ack on either port, state IDLE, then the next a_stb is served normally.
REQ-023 Spurious ram_ack=1 in IDLE with no stb -> no ack, all data_out unchanged.
